// File: rtl/adder_serial.sv
// Multi-cycle ripple adder/subtractor: N-bit operands consumed D bits per clock
// through a single carry register, behind a start/ready/busy/done handshake.
module adder_serial #(
  parameter int N = 32,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  generate
    if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
      $error("adder_serial: N must be >= 2 and a multiple of D, with 1 <= D <= N");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [N-1:0]  r_res;
  logic          r_carry;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  r_sum;
  logic          r_c_out;
  logic          r_ovf;

  logic [D:0]    w_digit;
  logic [N-1:0]  w_res_next;
  logic          w_last;
  logic          w_cin_msb;
  logic          w_finish;

  // One D-bit ripple per cycle; bit D of the digit sum is the carry into the next digit.
  assign w_digit    = {1'b0, r_sa[D-1:0]} + {1'b0, r_sb[D-1:0]} + {{D{1'b0}}, r_carry};
  assign w_res_next = (r_res >> D) | (N'(w_digit[D-1:0]) << (N - D));
  assign w_last     = (r_cnt == LAST_DIGIT);
  assign w_finish   = (r_state == S_BUSY) && w_last;
  // On the last digit, the carry into its top bit is the carry into bit N-1.
  assign w_cin_msb  = r_sa[D-1] ^ r_sb[D-1] ^ w_digit[D-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: the operand/result shift registers are fully loaded on acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_sa    <= a;
      r_sb    <= b ^ {N{sub}};
      r_carry <= sub;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == S_BUSY) begin
      r_sa    <= r_sa >> D;
      r_sb    <= r_sb >> D;
      r_res   <= w_res_next;
      r_carry <= w_digit[D];
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_finish) begin
      r_sum   <= w_res_next;
      r_c_out <= w_digit[D];
      r_ovf   <= w_cin_msb ^ w_digit[D];
    end
  end

  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_ovf;

endmodule
